// File: rtl/instr_fetch_unit.sv
// Fetch stage: PC, imem req/rvalid handshake, IR latch and next-PC select.
// One instruction in flight; FETCH -> WAIT -> ISSUE, HALT is terminal.
module instr_fetch_unit #(
    parameter int              ADDR_W   = 16,
    parameter int              INSTR_W  = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter logic [4:0]      HALT_OP  = 5'b11111
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               imem_rvalid,
    input  logic               stall,
    input  logic               pc_jump,
    input  logic               pc_branch,
    output logic [4:0]         opcode,
    output logic [INSTR_W-1:0] instr,
    output logic [ADDR_W-1:0]  instr_pc,
    output logic               instr_valid,
    output logic               halted,
    output logic [31:0]        retired
);

    typedef enum logic [1:0] {
        S_FETCH,
        S_WAIT,
        S_ISSUE,
        S_HALT
    } state_t;

    state_t             state;
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] ir;
    logic [ADDR_W-1:0]  br_off;
    logic [ADDR_W-1:0]  pc_seq;
    logic [ADDR_W-1:0]  pc_br;

    // Branch offset is IR[15:0] sign-extended, or truncated on narrow PCs.
    if (ADDR_W > 16) begin : g_sext
        assign br_off = {{(ADDR_W-16){ir[15]}}, ir[15:0]};
    end else begin : g_trunc
        assign br_off = ir[ADDR_W-1:0];
    end

    assign pc_seq    = instr_pc + {{(ADDR_W-1){1'b0}}, 1'b1};
    assign pc_br     = pc_seq + br_off;
    assign imem_addr = pc;
    assign instr     = ir;
    assign opcode    = ir[INSTR_W-1 -: 5];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_FETCH;
            pc          <= RESET_PC;
            ir          <= '0;
            instr_pc    <= '0;
            retired     <= '0;
            imem_req    <= 1'b0;
            instr_valid <= 1'b0;
            halted      <= 1'b0;
        end else begin
            unique case (state)
                S_FETCH: begin
                    state    <= S_WAIT;
                    imem_req <= 1'b1;
                end
                S_WAIT: begin
                    if (imem_rvalid) begin
                        ir          <= imem_rdata;
                        instr_pc    <= pc;
                        state       <= S_ISSUE;
                        imem_req    <= 1'b0;
                        instr_valid <= 1'b1;
                    end
                end
                S_ISSUE: begin
                    if (!stall) begin
                        retired     <= retired + 32'd1;
                        instr_valid <= 1'b0;
                        if (opcode == HALT_OP) begin
                            state  <= S_HALT;
                            halted <= 1'b1;
                        end else begin
                            state    <= S_FETCH;
                            imem_req <= 1'b1;
                            if (pc_jump)
                                pc <= ir[ADDR_W-1:0];
                            else if (pc_branch)
                                pc <= pc_br;
                            else
                                pc <= pc_seq;
                        end
                    end
                end
                S_HALT: begin
                    state <= S_HALT;
                end
                default: begin
                    state <= S_FETCH;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed steps plus random control-flow walk
// checked against a sparse-memory program model.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_rvalid;
    logic        stall;
    logic        pc_jump;
    logic        pc_branch;
    logic [4:0]  opcode;
    logic [31:0] instr;
    logic [15:0] instr_pc;
    logic        instr_valid;
    logic        halted;
    logic [31:0] retired;

    instr_fetch_unit dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .imem_rvalid (imem_rvalid),
        .stall       (stall),
        .pc_jump     (pc_jump),
        .pc_branch   (pc_branch),
        .opcode      (opcode),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_valid (instr_valid),
        .halted      (halted),
        .retired     (retired)
    );

    always #5 clk = ~clk;

    int          total = 0;
    int          bad   = 0;
    int          lat   = 1;
    bit          spur  = 1'b0;
    int          cnt   = 0;
    logic [31:0] mem [int];

    logic [15:0] exp_pc;
    logic [31:0] exp_ret;
    logic [31:0] last_w;
    bit          exp_halt;

    function automatic logic [31:0] word_at(int a);
        logic [31:0] w;
        if (!mem.exists(a)) begin
            w = $urandom;
            if (w[31:27] == 5'b11111)
                w[31:27] = 5'b00000;
            mem[a] = w;
        end
        return mem[a];
    endfunction

    // Memory answers after lat cycles of continuous request.
    always @(negedge clk) begin
        if (!rst_n || !imem_req) begin
            cnt         = 0;
            imem_rvalid = 1'b0;
        end else begin
            imem_rvalid = (cnt >= lat);
            imem_rdata  = word_at(int'(imem_addr));
            cnt++;
        end
        if (spur) begin
            imem_rvalid = 1'b1;
            imem_rdata  = 32'hDEAD_BEEF;
        end
    end

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic issue_one(input bit j, input bit b, input int st);
        int          n;
        logic [31:0] w;
        n = 0;
        while (n < 60) begin
            if (instr_valid)
                break;
            if (imem_req)
                chk("wait_addr", 64'(imem_addr), 64'(exp_pc));
            chk("wait_ir", 64'(instr), 64'(last_w));
            @(negedge clk);
            n++;
        end
        chk("valid_timeout", 64'(instr_valid), 64'd1);
        w = word_at(int'(exp_pc));
        chk("opcode", 64'(opcode), 64'(w[31:27]));
        chk("instr", 64'(instr), 64'(w));
        chk("instr_pc", 64'(instr_pc), 64'(exp_pc));
        chk("retired", 64'(retired), 64'(exp_ret));
        chk("issue_req", 64'(imem_req), 64'd0);
        pc_jump   = j;
        pc_branch = b;
        for (int i = 0; i < st; i++) begin
            stall = 1'b1;
            @(negedge clk);
            chk("stall_valid", 64'(instr_valid), 64'd1);
            chk("stall_op", 64'(opcode), 64'(w[31:27]));
            chk("stall_pc", 64'(instr_pc), 64'(exp_pc));
            chk("stall_ret", 64'(retired), 64'(exp_ret));
            chk("stall_req", 64'(imem_req), 64'd0);
        end
        stall = 1'b0;
        @(posedge clk);
        #1;
        pc_jump   = 1'b0;
        pc_branch = 1'b0;
        exp_ret   = exp_ret + 32'd1;
        last_w    = w;
        if (w[31:27] == 5'b11111)
            exp_halt = 1'b1;
        else if (j)
            exp_pc = w[15:0];
        else if (b)
            exp_pc = 16'(int'(exp_pc) + 1 + int'(signed'(w[15:0])));
        else
            exp_pc = 16'(int'(exp_pc) + 1);
        @(negedge clk);
        chk("valid_drop", 64'(instr_valid), 64'd0);
        if (exp_halt) begin
            chk("halted", 64'(halted), 64'd1);
        end else begin
            chk("next_req", 64'(imem_req), 64'd1);
            chk("next_addr", 64'(imem_addr), 64'(exp_pc));
        end
    endtask

    initial begin
        rst_n       = 1'b0;
        stall       = 1'b0;
        pc_jump     = 1'b0;
        pc_branch   = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        lat         = 10;
        exp_pc      = '0;
        exp_ret     = '0;
        last_w      = '0;
        exp_halt    = 1'b0;

        mem[0]       = {5'b00000, 27'h0000001};
        mem[1]       = {5'b00100, 27'h0000002};
        mem[2]       = {5'b00011, 27'h0000003};
        mem[3]       = {5'b01001, 11'h000, 16'h0005};
        mem[5]       = {5'b01001, 11'h000, 16'h0040};
        mem['h40]    = {5'b01001, 11'h000, 16'h0010};
        mem['h10]    = {5'b00110, 11'h000, 16'hFFFC};
        mem['h0D]    = {5'b01001, 11'h000, 16'hFFFF};
        mem['hFFFF]  = {5'b00001, 11'h000, 16'h7777};

        repeat (2) @(negedge clk);
        chk("rst_req", 64'(imem_req), 64'd0);
        chk("rst_valid", 64'(instr_valid), 64'd0);
        chk("rst_halted", 64'(halted), 64'd0);
        chk("rst_opcode", 64'(opcode), 64'd0);
        chk("rst_retired", 64'(retired), 64'd0);

        rst_n = 1'b1;
        @(negedge clk);
        chk("boot_req", 64'(imem_req), 64'd1);
        chk("boot_addr", 64'(imem_addr), 64'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_req", 64'(imem_req), 64'd0);
        chk("mid_rst_valid", 64'(instr_valid), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        lat   = 1;
        @(negedge clk);
        chk("rel_req", 64'(imem_req), 64'd1);
        chk("rel_addr", 64'(imem_addr), 64'd0);
        chk("rel_retired", 64'(retired), 64'd0);
        chk("rel_halted", 64'(halted), 64'd0);

        issue_one(1'b0, 1'b0, 0);
        issue_one(1'b0, 1'b0, 0);
        issue_one(1'b0, 1'b0, 0);

        issue_one(1'b1, 1'b0, 0);
        issue_one(1'b1, 1'b0, 0);
        issue_one(1'b1, 1'b1, 0);
        issue_one(1'b0, 1'b1, 0);
        issue_one(1'b1, 1'b0, 0);
        issue_one(1'b0, 1'b0, 0);

        lat = 5;
        issue_one(1'b0, 1'b0, 4);

        repeat (40) begin
            lat = $urandom_range(1, 4);
            issue_one(1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)),
                      $urandom_range(0, 2));
        end

        lat = 1;
        mem[int'(exp_pc)] = {5'b11111, 27'h0ABCDE};
        issue_one(1'b0, 1'b0, 0);
        for (int i = 0; i < 20; i++) begin
            spur = (i >= 5 && i < 9);
            @(negedge clk);
            chk("halt_req", 64'(imem_req), 64'd0);
            chk("halt_flag", 64'(halted), 64'd1);
            chk("halt_valid", 64'(instr_valid), 64'd0);
            chk("halt_ret", 64'(retired), 64'(exp_ret));
            chk("halt_ir", 64'(instr), 64'(last_w));
        end
        spur = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
